// File: rtl/tft_spi_tx.sv
// SPI mode-0 byte transmitter for the TFT panel link: serialises one byte MSB-first
// with a latched D/C line and per-byte chip select.
module tft_spi_tx #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tft_data,
  input  logic       tft_dc,
  input  logic       tft_transmit,
  output logic       tft_busy,
  output logic       spi_sck,
  output logic       spi_mosi,
  output logic       spi_dc,
  output logic       spi_cs
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StShiftLo = 2'd1;
  localparam logic [1:0] StShiftHi = 2'd2;
  localparam logic [1:0] StTail    = 2'd3;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       dc_q, dc_d;
  logic       cs_q, cs_d;
  logic       busy_q, busy_d;

  logic div_done;
  assign div_done = (div_q == DivLast);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    dc_d    = dc_q;
    cs_d    = cs_q;
    busy_d  = busy_q;

    case (state_q)
      StIdle: begin
        if (tft_transmit) begin
          shreg_d = tft_data;
          dc_d    = tft_dc;
          cs_d    = 1'b0;
          mosi_d  = tft_data[7];
          busy_d  = 1'b1;
          bit_d   = 3'd0;
          div_d   = 8'd0;
          state_d = StShiftLo;
        end
      end
      StShiftLo: begin
        if (div_done) begin
          div_d   = 8'd0;
          sck_d   = 1'b1;
          state_d = StShiftHi;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StShiftHi: begin
        if (div_done) begin
          div_d = 8'd0;
          sck_d = 1'b0;
          if (bit_q == 3'd7) begin
            state_d = StTail;
          end else begin
            // Next bit goes out on the same edge SCK falls.
            shreg_d = {shreg_q[6:0], 1'b0};
            mosi_d  = shreg_q[6];
            bit_d   = bit_q + 3'd1;
            state_d = StShiftLo;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StTail: begin
        if (div_done) begin
          div_d   = 8'd0;
          cs_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      div_q   <= 8'd0;
      bit_q   <= 3'd0;
      shreg_q <= 8'd0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      dc_q    <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      dc_q    <= dc_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
    end
  end

  assign tft_busy = busy_q;
  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;
  assign spi_dc   = dc_q;
  assign spi_cs   = cs_q;

endmodule

// File: tb/tb_tft_spi_tx.sv
// Directed bench for tft_spi_tx: two instances (CLK_DIV=2 and CLK_DIV=1) share clock,
// reset and byte inputs; each has its own strobe.
module tb_tft_spi_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       dc;
  logic       tx2, tx1;
  logic       busy2, sck2, mosi2, dc2, cs2;
  logic       busy1, sck1, mosi1, dc1, cs1;
  logic       sel;
  logic       m_busy, m_sck, m_mosi, m_dc, m_cs;

  int total = 0;
  int bad   = 0;

  int         g_busy, g_cs, g_bits, g_dc_bad, g_first, g_last;
  logic [7:0] g_byte;

  always #5 clk = ~clk;

  tft_spi_tx #(.CLK_DIV(2)) u_div2 (
    .clk(clk), .rst(rst), .tft_data(data), .tft_dc(dc), .tft_transmit(tx2),
    .tft_busy(busy2), .spi_sck(sck2), .spi_mosi(mosi2), .spi_dc(dc2), .spi_cs(cs2)
  );

  tft_spi_tx #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .tft_data(data), .tft_dc(dc), .tft_transmit(tx1),
    .tft_busy(busy1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_dc(dc1), .spi_cs(cs1)
  );

  assign m_busy = sel ? busy1 : busy2;
  assign m_sck  = sel ? sck1  : sck2;
  assign m_mosi = sel ? mosi1 : mosi2;
  assign m_dc   = sel ? dc1   : dc2;
  assign m_cs   = sel ? cs1   : cs2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_tx(input logic v);
    if (sel) tx1 = v;
    else     tx2 = v;
  endtask

  // Strobe one byte, then watch the frame until busy drops; optionally re-strobe 0xFF
  // (with the opposite D/C) at iteration strobe_at, which must be ignored.
  task automatic send(input logic [7:0] d, input logic c, input int strobe_at);
    logic prev;
    data = d;
    dc   = c;
    set_tx(1'b1);
    tick();
    set_tx(1'b0);
    g_busy = 0; g_cs = 0; g_bits = 0; g_dc_bad = 0; g_first = -1; g_last = -1;
    g_byte = 8'h00;
    prev   = 1'b0;
    for (int k = 0; k < 600 && m_busy === 1'b1; k++) begin
      g_busy++;
      if (m_cs === 1'b0) g_cs++;
      if (m_dc !== c) g_dc_bad++;
      if (m_sck === 1'b1 && prev === 1'b0) begin
        g_byte = {g_byte[6:0], m_mosi};
        g_bits++;
        if (g_first < 0) g_first = k;
        g_last = k;
      end
      prev = m_sck;
      if (k == strobe_at) begin
        data = 8'hFF;
        dc   = ~c;
        set_tx(1'b1);
      end else begin
        set_tx(1'b0);
      end
      tick();
    end
    set_tx(1'b0);
    check("busy_timeout", {31'd0, m_busy}, 32'd0);
  endtask

  // Count CS-low cycles and SCK rises over n idle cycles.
  task automatic quiet(input int n, output int cs_low, output int rises);
    logic prev;
    cs_low = 0;
    rises  = 0;
    prev   = m_sck;
    for (int k = 0; k < n; k++) begin
      if (m_cs !== 1'b1) cs_low++;
      if (m_sck === 1'b1 && prev !== 1'b1) rises++;
      prev = m_sck;
      tick();
    end
  endtask

  int ncs, nrise;

  initial begin
    rst = 1'b1; data = 8'h00; dc = 1'b0; tx2 = 1'b0; tx1 = 1'b0; sel = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset values
    check("rst_cs",   {31'd0, cs2},   32'd1);
    check("rst_sck",  {31'd0, sck2},  32'd0);
    check("rst_mosi", {31'd0, mosi2}, 32'd0);
    check("rst_dc",   {31'd0, dc2},   32'd0);
    check("rst_busy", {31'd0, busy2}, 32'd0);
    check("rst_cs1",  {31'd0, cs1},   32'd1);

    // Data byte 0xA5, CLK_DIV=2
    sel = 1'b0;
    send(8'hA5, 1'b1, -1);
    check("a5_byte", {24'd0, g_byte}, 32'hA5);
    check("a5_bits", g_bits, 32'd8);
    check("a5_busy", g_busy, 32'd34);
    check("a5_cs",   g_cs,   32'd34);
    check("a5_dc",   g_dc_bad, 32'd0);
    check("a5_span", g_last - g_first, 32'd28);
    check("a5_cs_end", {31'd0, cs2}, 32'd1);

    // Command byte 0x3C, CLK_DIV=1
    sel = 1'b1;
    send(8'h3C, 1'b0, -1);
    check("3c_byte", {24'd0, g_byte}, 32'h3C);
    check("3c_bits", g_bits, 32'd8);
    check("3c_busy", g_busy, 32'd17);
    check("3c_first", g_first, 32'd1);
    check("3c_span", g_last - g_first, 32'd14);
    check("3c_dc",   g_dc_bad, 32'd0);
    check("3c_dc_line", {31'd0, dc1}, 32'd0);

    // Strobe while busy is dropped
    sel = 1'b0;
    send(8'h11, 1'b1, 10);
    check("busy_byte", {24'd0, g_byte}, 32'h11);
    check("busy_busy", g_busy, 32'd34);
    check("busy_dc",   g_dc_bad, 32'd0);
    check("mosi_hold", {31'd0, mosi2}, 32'd1);
    quiet(40, ncs, nrise);
    check("busy_no_frame", ncs, 32'd0);
    check("busy_no_sck",   nrise, 32'd0);

    // Back-to-back: strobe on the first idle cycle
    send(8'h80, 1'b1, -1);
    check("b2b_byte0", {24'd0, g_byte}, 32'h80);
    check("b2b_gap_cs", {31'd0, cs2}, 32'd1);
    send(8'h01, 1'b1, -1);
    check("b2b_byte1", {24'd0, g_byte}, 32'h01);
    check("b2b_cs1",   g_cs, 32'd34);

    // Reset mid-byte
    data = 8'hF0; dc = 1'b1; tx2 = 1'b1;
    tick();
    tx2 = 1'b0;
    repeat (9) tick();
    check("mid_mosi_pre", {31'd0, mosi2}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_cs",   {31'd0, cs2},   32'd1);
    check("mid_sck",  {31'd0, sck2},  32'd0);
    check("mid_mosi", {31'd0, mosi2}, 32'd0);
    check("mid_busy", {31'd0, busy2}, 32'd0);
    check("mid_dc",   {31'd0, dc2},   32'd0);
    send(8'h5A, 1'b1, -1);
    check("post_byte", {24'd0, g_byte}, 32'h5A);
    check("post_busy", g_busy, 32'd34);

    // Reset and strobe on the same edge
    rst = 1'b1; tx2 = 1'b1; data = 8'hFF; dc = 1'b1;
    tick();
    rst = 1'b0; tx2 = 1'b0;
    check("rs_busy", {31'd0, busy2}, 32'd0);
    check("rs_cs",   {31'd0, cs2},   32'd1);
    check("rs_mosi", {31'd0, mosi2}, 32'd0);
    check("rs_dc",   {31'd0, dc2},   32'd0);
    quiet(40, ncs, nrise);
    check("rs_no_cs",  ncs, 32'd0);
    check("rs_no_sck", nrise, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
